// File: rtl/sram_pipe_pkg.sv
// Shared types and helpers for sram_pipe: sweep/run state encoding,
// read-latency bounds and the byte-parity function.
package sram_pipe_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline for sram_pipe: stage 0 captures the array word on an
// accepted read, the remaining RD_LAT-1 stages shift it towards the output.
module sram_rd_pipe
  import sram_pipe_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [LAT-1:0] valid_r;
  logic [W-1:0]   data_r [LAT];

  // Capture on accept and shift; reset flushes every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        data_r[0] <= in_data;
      end else begin
        data_r[0] <= data_r[0];
      end
      for (int i = 1; i < LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[LAT-1];
  assign out_data  = data_r[LAT-1];

endmodule

// File: rtl/sram_pipe.sv
// sram_pipe: single-port RAM with byte enables, a clear sweep after reset and
// a configurable read pipeline. Define SRAM_PAR_EN for per-byte even parity.
module sram_pipe
  import sram_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                wr,
  input  logic                oe,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                rd_valid,
  output logic                busy
`ifdef SRAM_PAR_EN
  ,
  input  logic                par_inj,
  output logic                par_err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SRAM_PAR_EN
  localparam int PW = DATA_W + 1;
`else
  localparam int PW = DATA_W;
`endif

  state_e            state_r, state_nxt_s;
  logic [ADDR_W-1:0] clr_addr_r, clr_addr_nxt_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_en_s, rd_en_s;
  logic [PW-1:0]     rd_payload_s, pipe_data_s;
  logic              pipe_valid_s;
`ifdef SRAM_PAR_EN
  logic [NB-1:0]     par_mem_r [DEPTH];
`endif

  // Sweep/run state and sweep address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= CLEAR;
      clr_addr_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      clr_addr_r <= clr_addr_nxt_s;
    end
  end

  // Sweep every address once, leaving CLEAR after the last one is written.
  always_comb begin
    state_nxt_s    = state_r;
    clr_addr_nxt_s = clr_addr_r;
    case (state_r)
      CLEAR: begin
        clr_addr_nxt_s = clr_addr_r + ADDR_W'(1);
        if (&clr_addr_r) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = CLEAR;
    endcase
  end

  assign busy    = (state_r == CLEAR);
  assign wr_en_s = cs & wr & ~busy;
  assign rd_en_s = cs & ~wr & ~busy;

  // Array update: sweep zeros during CLEAR, byte-masked writes in RUN.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_r[clr_addr_r] <= '0;
`ifdef SRAM_PAR_EN
      par_mem_r[clr_addr_r] <= '0;
`endif
    end else if (wr_en_s) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
`ifdef SRAM_PAR_EN
          par_mem_r[addr][i] <= byte_par(wdata[8*i +: 8]) ^ par_inj;
`endif
        end
      end
    end
  end

  // Array word (plus parity check result) captured into the pipeline.
  always_comb begin
    rd_payload_s = '0;
    rd_payload_s[DATA_W-1:0] = mem_r[addr];
`ifdef SRAM_PAR_EN
    for (int i = 0; i < NB; i++) begin
      rd_payload_s[DATA_W] = rd_payload_s[DATA_W] |
                             (byte_par(mem_r[addr][8*i +: 8]) ^ par_mem_r[addr][i]);
    end
`endif
  end

  sram_rd_pipe #(
    .RD_LAT (RD_LAT),
    .W      (PW)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en_s),
    .in_data   (rd_payload_s),
    .out_valid (pipe_valid_s),
    .out_data  (pipe_data_s)
  );

  assign rd_valid = pipe_valid_s;
  assign rdata    = oe ? pipe_data_s[DATA_W-1:0] : '0;
`ifdef SRAM_PAR_EN
  assign par_err  = pipe_valid_s & pipe_data_s[DATA_W];
`endif

endmodule

// File: tb/tb_sram_pipe.sv
// Directed self-checking bench for sram_pipe (RD_LAT=3, 32x256); parity
// checks are included when SRAM_PAR_EN is defined.
module tb_sram_pipe;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic        oe = 1'b1;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be = 4'h0;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        busy;
`ifdef SRAM_PAR_EN
  logic        par_inj = 1'b0;
  logic        par_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_clr;
  bit seen_v;
  logic [7:0]  b_addr [4];
  logic [31:0] b_exp [4];

  sram_pipe #(.DATA_W(32), .ADDR_W(8), .RD_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .wr       (wr),
    .oe       (oe),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .busy     (busy)
`ifdef SRAM_PAR_EN
    ,
    .par_inj  (par_inj),
    .par_err  (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                         input bit inj);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
`ifdef SRAM_PAR_EN
    par_inj = inj;
`else
    if (inj) $display("note: parity inject ignored in this build");
`endif
    tick();
    cs = 1'b0; wr = 1'b0;
`ifdef SRAM_PAR_EN
    par_inj = 1'b0;
`endif
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp,
                        input bit exp_err);
    cs = 1'b1; wr = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    repeat (LAT - 1) tick();
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk({tag, "_data"}, rdata, exp);
`ifdef SRAM_PAR_EN
    chk({tag, "_perr"}, {31'd0, par_err}, {31'd0, exp_err});
`else
    if (exp_err) $display("note: parity expectation skipped in this build");
`endif
    tick();
    chk({tag, "_valid_end"}, {31'd0, rd_valid}, 32'd0);
  endtask

  // Four back-to-back reads from b_addr; oe held low during beat oe_beat.
  task automatic burst(input int oe_beat);
    for (int j = 1; j <= 4 + LAT; j++) begin
      if (j <= 4) begin
        cs = 1'b1; wr = 1'b0; addr = b_addr[j-1];
      end else begin
        cs = 1'b0;
      end
      oe = (j - LAT == oe_beat) ? 1'b0 : 1'b1;
      tick();
      if (j >= LAT && j < LAT + 4) begin
        chk($sformatf("burst_valid%0d", j - LAT), {31'd0, rd_valid}, 32'd1);
        chk($sformatf("burst_data%0d", j - LAT), rdata,
            (j - LAT == oe_beat) ? 32'h0 : b_exp[j-LAT]);
      end else begin
        chk($sformatf("burst_idle%0d", j), {31'd0, rd_valid}, 32'd0);
      end
    end
    oe = 1'b1;
  endtask

  // Bounded wait for the clear sweep, optionally poking accesses into it.
  task automatic wait_clear(input bit drop, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (busy && n < 400) begin
      if (drop && n == 10) begin
        cs = 1'b1; wr = 1'b1; addr = 8'h05; wdata = 32'h55; be = 4'hF;
      end else if (drop && n == 11) begin
        cs = 1'b1; wr = 1'b0; addr = 8'h05;
      end else begin
        cs = 1'b0; wr = 1'b0;
      end
      tick();
      n++;
      if (rd_valid) seen = 1'b1;
    end
    cs = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
`ifdef SRAM_PAR_EN
    chk("rst_perr", {31'd0, par_err}, 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    wait_clear(1'b1, n_clr, seen_v);
    chk("clear_cycles", n_clr, 32'd256);
    chk("clear_no_valid", {31'd0, seen_v}, 32'd0);

    rd_chk("rd_00", 8'h00, 32'h0, 1'b0);
    rd_chk("rd_7f", 8'h7F, 32'h0, 1'b0);
    rd_chk("rd_ff", 8'hFF, 32'h0, 1'b0);
    rd_chk("rd_dropped", 8'h05, 32'h0, 1'b0);

    wr_word(8'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    wr_word(8'h10, 32'h00001200, 4'h2, 1'b0);
    rd_chk("rd_be", 8'h10, 32'hDEAD12EF, 1'b0);

    for (int k = 0; k < 4; k++) begin
      wr_word(8'(k), 32'hA0 + 32'(k), 4'hF, 1'b0);
      b_addr[k] = 8'(k);
      b_exp[k]  = 32'hA0 + 32'(k);
    end
    wr_word(8'h01, 32'hFFFFFFFF, 4'h0, 1'b0);
    burst(2);
    burst(9);

`ifdef SRAM_PAR_EN
    wr_word(8'h20, 32'h11223344, 4'h1, 1'b1);
    rd_chk("par_inj", 8'h20, 32'h00000044, 1'b1);
    wr_word(8'h20, 32'h11223344, 4'h1, 1'b0);
    rd_chk("par_ok", 8'h20, 32'h00000044, 1'b0);
`endif

    cs = 1'b1; wr = 1'b0; addr = 8'h00;
    tick();
    addr = 8'h01;
    tick();
    cs = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_valid", {31'd0, rd_valid}, 32'd0);
    tick();
    rst = 1'b0;
    wait_clear(1'b0, n_clr, seen_v);
    chk("reclear_cycles", n_clr, 32'd256);
    chk("reclear_no_valid", {31'd0, seen_v}, 32'd0);
    rd_chk("rd_lost", 8'h10, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
